// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Central sequencer for the pipeline latches (fetch/decode/execute/memory).
//   It drives each latch's en/flush pair and pc_en from the following events:
//   memory wait, load-use, branch/jump redirect and halt. It is a pure control
//   block, so no datapath words pass through it.
//   FSM states: INIT (after reset), RUN, DWAIT (frozen on a data miss) and
//   HALT (absorbing until reset). The state is registered. The latch controls
//   are combinational from the state and the inputs. A latch flush always
//   wins over its enable, so en is never raised together with flush.
//
// Optional feature (macro HAZARD_PERF_EN):
//   Adds the saturating counters stall_cnt, flush_cnt and wait_cnt (CNT_W bits
//   each). The counters freeze in HALT.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit, dhit           instruction / data access complete this cycle
//   mem_dREN, mem_dWEN   MEM-stage load / store in flight
//   ex_dREN, ex_Rt       EX-stage load and its destination register
//   id_Rs, id_Rt         ID-stage source registers
//   pc_redirect          taken branch/jump resolved in EX
//   wb_halt              halt instruction in writeback
//   pc_en                PC update enable
//   {fl,dl,el,ml}_en     latch enables
//   {fl,dl,el,ml}_flush  latch flushes
//   halted               registered; high once a halt has retired
//   stall_cnt, flush_cnt, wait_cnt   (HAZARD_PERF_EN only)
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_Rt,
    input  logic [REG_W-1:0] id_Rs,
    input  logic [REG_W-1:0] id_Rt,
    input  logic             pc_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             fl_en,
    output logic             fl_flush,
    output logic             dl_en,
    output logic             dl_flush,
    output logic             el_en,
    output logic             el_flush,
    output logic             ml_en,
    output logic             ml_flush,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
`endif
    output logic             halted
);

    typedef enum logic [1:0] {INIT, RUN, DWAIT, HALT} state_t;

    state_t state_reg;
    state_t state_next;

    logic mem_busy;
    logic load_use;
    logic redirect_go;
    logic advance;

    // Widths of zero are meaningless for either parameter.
    if (CNT_W < 1 || REG_W < 1) begin : g_param_check
        $error("pipeline_hazard_ctrl: CNT_W and REG_W must be positive");
    end

    assign mem_busy    = (mem_dREN | mem_dWEN) & ~dhit;
    assign load_use    = ex_dREN & (ex_Rt != '0) & ((ex_Rt == id_Rs) | (ex_Rt == id_Rt));
    // A redirect takes effect only together with ihit. Without ihit it stays
    // pending in EX and the miss bubble applies instead.
    assign redirect_go = pc_redirect & ihit;

    // Controls used whenever the back end may advance. This covers both the
    // normal RUN path and the DWAIT release cycle.
    logic adv_pc_en, adv_fl_en, adv_fl_flush, adv_dl_en, adv_dl_flush;
    always_comb begin
        adv_pc_en    = 1'b0;
        adv_fl_en    = 1'b0;
        adv_fl_flush = 1'b0;
        adv_dl_en    = 1'b0;
        adv_dl_flush = 1'b0;
        if (redirect_go) begin
            adv_pc_en    = 1'b1;
            adv_fl_flush = 1'b1;
            adv_dl_flush = 1'b1;
        end else if (!ihit) begin
            adv_fl_flush = 1'b1;
            adv_dl_en    = 1'b1;
        end else if (load_use) begin
            adv_dl_flush = 1'b1;
        end else begin
            adv_pc_en = 1'b1;
            adv_fl_en = 1'b1;
            adv_dl_en = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        pc_en      = 1'b0;
        fl_en      = 1'b0;
        fl_flush   = 1'b0;
        dl_en      = 1'b0;
        dl_flush   = 1'b0;
        el_en      = 1'b0;
        el_flush   = 1'b0;
        ml_en      = 1'b0;
        ml_flush   = 1'b0;
        case (state_reg)
            INIT: begin
                fl_flush   = 1'b1;
                dl_flush   = 1'b1;
                el_flush   = 1'b1;
                ml_flush   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (wb_halt) begin
                    state_next = HALT;
                end else if (mem_busy) begin
                    state_next = DWAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    advance    = 1'b1;
                    state_next = RUN;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = INIT;
        endcase
        if (advance) begin
            pc_en    = adv_pc_en;
            fl_en    = adv_fl_en;
            fl_flush = adv_fl_flush;
            dl_en    = adv_dl_en;
            dl_flush = adv_dl_flush;
            el_en    = 1'b1;
            ml_en    = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= INIT;
            halted    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RUN && wb_halt) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_hit, flush_hit, wait_hit;
    assign stall_hit = advance & ~redirect_go & ihit & load_use;
    assign flush_hit = advance & redirect_go;
    // Count memory-frozen cycles only. The DWAIT release cycle moves the
    // pipeline, so it is not counted.
    assign wait_hit  = ((state_reg == RUN) & ~wb_halt & mem_busy) |
                       ((state_reg == DWAIT) & ~dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall_hit && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_hit && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            if (wait_hit  && wait_cnt  != '1) wait_cnt  <= wait_cnt  + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    logic             CLK = 1'b0;
    logic             nRST = 1'b1;
    logic             ihit = 1'b0, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0;
    logic             ex_dREN = 1'b0, pc_redirect = 1'b0, wb_halt = 1'b0;
    logic [REG_W-1:0] ex_Rt = '0, id_Rs = '0, id_Rt = '0;
    logic             pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush;
    logic             halted;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
        .ex_Rt(ex_Rt), .id_Rs(id_Rs), .id_Rt(id_Rt),
        .pc_redirect(pc_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .fl_en(fl_en), .fl_flush(fl_flush),
        .dl_en(dl_en), .dl_flush(dl_flush), .el_en(el_en), .el_flush(el_flush),
        .ml_en(ml_en), .ml_flush(ml_flush),
`ifdef HAZARD_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
`endif
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    int chk_cnt = 0;
    int err_cnt = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // The model has pipeline modes. Each latch gets an action: hold, advance
    // or bubble.
    localparam int M_INIT = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;
    localparam int HOLD = 0, ADV = 1, BUB = 2;
    int m_mode   = M_INIT;
    bit m_halted = 1'b0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_mode   <= M_INIT;
            m_halted <= 1'b0;
        end else begin
            case (m_mode)
                M_INIT: m_mode <= M_RUN;
                M_RUN: begin
                    if (wb_halt) begin
                        m_mode   <= M_HALT;
                        m_halted <= 1'b1;
                    end else if ((mem_dREN || mem_dWEN) && !dhit) begin
                        m_mode <= M_WAIT;
                    end
                end
                M_WAIT: if (dhit) m_mode <= M_RUN;
                default: m_mode <= M_HALT;
            endcase
        end
    end

    // Returns {pc, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush}
    function automatic logic [8:0] expected_ctrl(input int mode);
        int  fl, dl, el, ml;
        bit  pc;
        bit  moving;
        bit  hazard;
        pc = 1'b0; fl = HOLD; dl = HOLD; el = HOLD; ml = HOLD;
        moving = 1'b0;
        if (mode == M_INIT) begin
            fl = BUB; dl = BUB; el = BUB; ml = BUB;
        end else if (mode == M_RUN) begin
            moving = !wb_halt && !((mem_dREN || mem_dWEN) && !dhit);
        end else if (mode == M_WAIT) begin
            moving = dhit;
        end
        if (moving) begin
            el = ADV; ml = ADV;
            hazard = ex_dREN && ex_Rt != 0 && (ex_Rt == id_Rs || ex_Rt == id_Rt);
            if (pc_redirect && ihit) begin
                pc = 1'b1; fl = BUB; dl = BUB;
            end else if (!ihit) begin
                fl = BUB; dl = ADV;
            end else if (hazard) begin
                fl = HOLD; dl = BUB;
            end else begin
                pc = 1'b1; fl = ADV; dl = ADV;
            end
        end
        return {pc, fl == ADV, fl == BUB, dl == ADV, dl == BUB,
                el == ADV, el == BUB, ml == ADV, ml == BUB};
    endfunction

    // Compare process: the outputs are meaningful on every cycle.
    always @(negedge CLK) begin
        if (chk_on) begin
            logic [8:0] e;
            e = expected_ctrl(m_mode);
            check("m_pc_en",    pc_en,    e[8]);
            check("m_fl_en",    fl_en,    e[7]);
            check("m_fl_flush", fl_flush, e[6]);
            check("m_dl_en",    dl_en,    e[5]);
            check("m_dl_flush", dl_flush, e[4]);
            check("m_el_en",    el_en,    e[3]);
            check("m_el_flush", el_flush, e[2]);
            check("m_ml_en",    ml_en,    e[1]);
            check("m_ml_flush", ml_flush, e[0]);
            check("m_halted",   halted,   m_halted);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; ex_dREN = 1'b0;
        ex_Rt = '0; id_Rs = '0; id_Rt = '0; pc_redirect = 1'b0; wb_halt = 1'b0;
    endtask

    initial begin
        int halt_cycles;
        bit in_reset;
        // ---------- reset ----------
        #1 nRST = 1'b0;
        #1 chk_on = 1'b1;
        @(negedge CLK);
        check("rst_pc_en", pc_en, 1'b0);
        check("rst_fl_flush", fl_flush, 1'b1);
        check("rst_ml_flush", ml_flush, 1'b1);
        check("rst_halted", halted, 1'b0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        idle_inputs();
        @(negedge CLK);
        check("init_dl_flush", dl_flush, 1'b1);
        check("init_el_en", el_en, 1'b0);
        $display("txn reset: INIT cycle pc_en=%0b fl_flush=%0b", pc_en, fl_flush);
        step();
        @(negedge CLK);
        check("run_pc_en", pc_en, 1'b1);
        check("run_fl_en", fl_en, 1'b1);
        check("run_ml_en", ml_en, 1'b1);

        // ---------- load-use ----------
        step(); ex_dREN = 1'b1; ex_Rt = 5'd5; id_Rs = 5'd5; id_Rt = 5'd0;
        @(negedge CLK);
        check("lu_pc_en", pc_en, 1'b0);
        check("lu_fl_en", fl_en, 1'b0);
        check("lu_dl_flush", dl_flush, 1'b1);
        check("lu_el_en", el_en, 1'b1);
        step(); id_Rs = 5'd1; id_Rt = 5'd5;
        @(negedge CLK);
        check("lu_rt_dl_flush", dl_flush, 1'b1);
        $display("txn load-use: pc_en=%0b fl_en=%0b dl_flush=%0b", pc_en, fl_en, dl_flush);
        step(); ex_Rt = 5'd0; id_Rs = 5'd0; id_Rt = 5'd0;
        @(negedge CLK);
        check("r0_pc_en", pc_en, 1'b1);
        check("r0_dl_flush", dl_flush, 1'b0);

        // ---------- data wait ----------
        step(); ex_dREN = 1'b0; mem_dREN = 1'b1; dhit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            @(negedge CLK);
            check("dw_pc_en", pc_en, 1'b0);
            check("dw_el_en", el_en, 1'b0);
            check("dw_ml_en", ml_en, 1'b0);
        end
        step(); dhit = 1'b1;
        @(negedge CLK);
        check("dhit_ml_en", ml_en, 1'b1);
        check("dhit_fl_en", fl_en, 1'b1);
        step(); mem_dREN = 1'b0; dhit = 1'b0;
        @(negedge CLK);
        check("after_dw_pc_en", pc_en, 1'b1);
        $display("txn data-wait: released, pc_en=%0b", pc_en);

        // ---------- redirect ----------
        step(); pc_redirect = 1'b1; ihit = 1'b1;
        @(negedge CLK);
        check("rd_pc_en", pc_en, 1'b1);
        check("rd_fl_flush", fl_flush, 1'b1);
        check("rd_dl_flush", dl_flush, 1'b1);
        check("rd_el_en", el_en, 1'b1);
        step(); ihit = 1'b0;
        @(negedge CLK);
        check("rdmiss_pc_en", pc_en, 1'b0);
        check("rdmiss_fl_flush", fl_flush, 1'b1);
        check("rdmiss_dl_flush", dl_flush, 1'b0);
        $display("txn redirect: miss variant dl_en=%0b", dl_en);
        step(); idle_inputs();
`ifdef HAZARD_PERF_EN
        @(negedge CLK);
        check("perf_stall", stall_cnt, 32'd2);
        check("perf_flush", flush_cnt, 32'd1);
        check("perf_wait", wait_cnt, 32'd3);
`endif

        // ---------- halt ----------
        step(); wb_halt = 1'b1;
        @(negedge CLK);
        check("halt_req_pc_en", pc_en, 1'b0);
        check("halt_req_el_en", el_en, 1'b0);
        step(); wb_halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ihit = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
            mem_dREN = 1'($urandom_range(0, 1));
            @(negedge CLK);
            check("halt_halted", halted, 1'b1);
            check("halt_pc_en", pc_en, 1'b0);
            check("halt_fl_en", fl_en, 1'b0);
            check("halt_ml_en", ml_en, 1'b0);
            step();
        end
        nRST = 1'b0;
        #1;
        check("halt_rst_halted", halted, 1'b0);
        check("halt_rst_fl_flush", fl_flush, 1'b1);
        $display("txn halt: held 10 cycles, reset returns to INIT");
        step(); nRST = 1'b1; idle_inputs();

        // ---------- randomized ----------
        halt_cycles = 0;
        in_reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (in_reset) begin
                nRST = 1'b1;
                in_reset = 1'b0;
            end
            ihit    = ($urandom_range(0, 3) != 0);
            dhit    = ($urandom_range(0, 2) == 0);
            if (m_mode != M_WAIT) begin
                mem_dREN = ($urandom_range(0, 3) == 0);
                mem_dWEN = !mem_dREN && ($urandom_range(0, 5) == 0);
            end
            ex_dREN     = ($urandom_range(0, 2) == 0);
            ex_Rt       = REG_W'($urandom_range(0, 3));
            id_Rs       = REG_W'($urandom_range(0, 3));
            id_Rt       = REG_W'($urandom_range(0, 3));
            pc_redirect = ($urandom_range(0, 5) == 0);
            wb_halt     = (m_mode == M_RUN) && ($urandom_range(0, 59) == 0);
            if (m_mode == M_HALT) halt_cycles++;
            if (halt_cycles > 8 || $urandom_range(0, 199) == 0) begin
                #2 nRST = 1'b0;
                in_reset = 1'b1;
                halt_cycles = 0;
                $display("txn random reset at cycle %0d", c);
            end
        end
        step();
        nRST = 1'b1;
        @(negedge CLK);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
